// File: rtl/raw_window_3x3.sv
// raw_window_3x3: line-buffered 3x3 raw Bayer neighbourhood with centre phase bits
// Ports: iCLK/iRST clock and sync active-high reset; iDATA/iDVAL raw pixel stream;
//        oP_0..oP_8 window (top 2|1|0, mid 5|4|3, bottom 8|7|6, index 0/3/6 newest);
//        oX_LSB/oY_LSB centre column/row bit 0 with phase; oDVAL one pulse per window.
// Build option RAW_WIN_FVAL_EN adds iFVAL: its rising edge restarts framing, iDVAL ignored while low.
module raw_window_3x3 #(
  parameter int LINE_WIDTH   = 1280,
  parameter int FRAME_HEIGHT = 960,
  parameter bit X_PHASE      = 1'b0,
  parameter bit Y_PHASE      = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRST,
`ifdef RAW_WIN_FVAL_EN
  input  logic        iFVAL,
`endif
  input  logic [11:0] iDATA,
  input  logic        iDVAL,
  output logic [11:0] oP_0,
  output logic [11:0] oP_1,
  output logic [11:0] oP_2,
  output logic [11:0] oP_3,
  output logic [11:0] oP_4,
  output logic [11:0] oP_5,
  output logic [11:0] oP_6,
  output logic [11:0] oP_7,
  output logic [11:0] oP_8,
  output logic        oX_LSB,
  output logic        oY_LSB,
  output logic        oDVAL
);
  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(FRAME_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [1:0] FILL0  = 2'd0;
  localparam logic [1:0] FILL1  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic [1:0] st_q, st_d, st_c;
  logic [2:0][11:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic x_q, x_d, y_q, y_d, dval_q, dval_d;
  logic [11:0] lb1_q [LINE_WIDTH];
  logic [11:0] lb2_q [LINE_WIDTH];
  logic [11:0] lb1_rd, lb2_rd;
  logic acc, rise, eol, eof;
`ifdef RAW_WIN_FVAL_EN
  logic fval_q;
  assign rise = iFVAL & ~fval_q;
  assign acc  = iDVAL & iFVAL;
  always_ff @(posedge iCLK) fval_q <= iRST ? 1'b0 : iFVAL;
`else
  assign rise = 1'b0;
  assign acc  = iDVAL;
`endif
  // a frame-valid rising edge restarts framing before this cycle's pixel is taken
  assign col_c = rise ? '0 : col_q;
  assign row_c = rise ? '0 : row_q;
  assign st_c  = rise ? FILL0 : st_q;
  assign eol = col_c == COL_LAST;
  assign eof = eol && row_c == ROW_LAST;
  assign lb1_rd = lb1_q[col_c];
  assign lb2_rd = lb2_q[col_c];
  always_comb begin
    col_d  = acc ? (eol ? '0 : col_c + 1'b1) : col_c;
    row_d  = acc && eol ? (eof ? '0 : row_c + 1'b1) : row_c;
    st_d   = !(acc && eol) ? st_c :
             st_c == FILL0 ? FILL1 :
             st_c == FILL1 ? STREAM :
             eof ? FILL0 : STREAM;
    top_d  = acc ? {top_q[1:0], lb2_rd} : top_q;
    mid_d  = acc ? {mid_q[1:0], lb1_rd} : mid_q;
    bot_d  = acc ? {bot_q[1:0], iDATA} : bot_q;
    x_d    = acc ? ~col_c[0] ^ X_PHASE : x_q;
    y_d    = acc ? ~row_c[0] ^ Y_PHASE : y_q;
    // columns 0/1 still hold the previous line, so only col >= 2 is exposed
    dval_d = acc && st_c == STREAM && col_c >= CW'(2);
  end
  always_ff @(posedge iCLK)
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      st_q   <= FILL0;
      top_q  <= '0;
      mid_q  <= '0;
      bot_q  <= '0;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      dval_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      st_q   <= st_d;
      top_q  <= top_d;
      mid_q  <= mid_d;
      bot_q  <= bot_d;
      x_q    <= x_d;
      y_q    <= y_d;
      dval_q <= dval_d;
    end
  always_ff @(posedge iCLK)
    if (acc) begin
      lb1_q[col_c] <= iDATA;
      lb2_q[col_c] <= lb1_rd;
    end
  assign oP_0 = top_q[0];
  assign oP_1 = top_q[1];
  assign oP_2 = top_q[2];
  assign oP_3 = mid_q[0];
  assign oP_4 = mid_q[1];
  assign oP_5 = mid_q[2];
  assign oP_6 = bot_q[0];
  assign oP_7 = bot_q[1];
  assign oP_8 = bot_q[2];
  assign oX_LSB = x_q;
  assign oY_LSB = y_q;
  assign oDVAL  = dval_q;
endmodule

// File: tb/tb_raw_window_3x3.sv
// tb_raw_window_3x3: image-model checked bench for raw_window_3x3
module tb_raw_window_3x3;
  localparam int W = 8;
  localparam int H = 6;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, dval = 1'b0, fval = 1'b1;
  logic [11:0] data = '0;
  logic [11:0] p0 [9];
  logic [11:0] p1 [9];
  logic x0, y0, v0, x1, y1, v1;
  raw_window_3x3 #(.LINE_WIDTH(W), .FRAME_HEIGHT(H)) dut0 (
    .iCLK(clk), .iRST(rst),
`ifdef RAW_WIN_FVAL_EN
    .iFVAL(fval),
`endif
    .iDATA(data), .iDVAL(dval),
    .oP_0(p0[0]), .oP_1(p0[1]), .oP_2(p0[2]), .oP_3(p0[3]), .oP_4(p0[4]),
    .oP_5(p0[5]), .oP_6(p0[6]), .oP_7(p0[7]), .oP_8(p0[8]),
    .oX_LSB(x0), .oY_LSB(y0), .oDVAL(v0));
  raw_window_3x3 #(.LINE_WIDTH(W), .FRAME_HEIGHT(H), .X_PHASE(1'b1), .Y_PHASE(1'b1)) dut1 (
    .iCLK(clk), .iRST(rst),
`ifdef RAW_WIN_FVAL_EN
    .iFVAL(fval),
`endif
    .iDATA(data), .iDVAL(dval),
    .oP_0(p1[0]), .oP_1(p1[1]), .oP_2(p1[2]), .oP_3(p1[3]), .oP_4(p1[4]),
    .oP_5(p1[5]), .oP_6(p1[6]), .oP_7(p1[7]), .oP_8(p1[8]),
    .oX_LSB(x1), .oY_LSB(y1), .oDVAL(v1));
  logic [11:0] img [H][W];
  logic [11:0] ep [9];
  logic [11:0] last [9];
  logic ex, ey, ex1, ey1, ev, lx, ly;
  bit cmp_all, hold, armed, prev_f;
  int mc, mr, checks, errors, pulses;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
    end
  endtask
  function automatic logic [11:0] pix(int r, int c);
    return 12'(r * 16 + c);
  endfunction
  task automatic cycle(bit r, bit d, logic [11:0] v, bit f = 1'b1);
    bit acc;
    rst = r;
    dval = d;
    data = v;
    fval = f;
    @(posedge clk);
    #1;
    ev = 1'b0;
    cmp_all = 1'b0;
    hold = 1'b0;
    if (r) begin
      mc = 0;
      mr = 0;
      prev_f = 1'b0;
      foreach (ep[i]) ep[i] = '0;
      ex = 1'b0; ey = 1'b0; ex1 = 1'b0; ey1 = 1'b0;
      cmp_all = 1'b1;
      armed = 1'b1;
    end else begin
      acc = d;
`ifdef RAW_WIN_FVAL_EN
      if (f && !prev_f) begin
        mc = 0;
        mr = 0;
      end
      acc = d && f;
      prev_f = f;
`endif
      hold = !acc;
      if (acc) begin
        img[mr][mc] = v;
        if (mc >= 2 && mr >= 2) begin
          ev = 1'b1;
          cmp_all = 1'b1;
          for (int k = 0; k < 9; k++) ep[k] = img[mr - 2 + k / 3][mc - k % 3];
          ex = (mc - 1) % 2 == 1;
          ey = (mr - 1) % 2 == 1;
          ex1 = !ex;
          ey1 = !ey;
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr + 1) % H;
        end
      end
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("oDVAL", 32'(v0), 32'(ev));
      chk("oDVAL_phase", 32'(v1), 32'(ev));
      if (v0) pulses++;
      if (cmp_all) begin
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("oP_%0d", k), 32'(p0[k]), 32'(ep[k]));
          chk($sformatf("phase_oP_%0d", k), 32'(p1[k]), 32'(ep[k]));
        end
        chk("oX_LSB", 32'(x0), 32'(ex));
        chk("oY_LSB", 32'(y0), 32'(ey));
        chk("phase_oX_LSB", 32'(x1), 32'(ex1));
        chk("phase_oY_LSB", 32'(y1), 32'(ey1));
      end
      if (hold) begin
        for (int k = 0; k < 9; k++) chk($sformatf("hold_oP_%0d", k), 32'(p0[k]), 32'(last[k]));
        chk("hold_oX_LSB", 32'(x0), 32'(lx));
        chk("hold_oY_LSB", 32'(y0), 32'(ly));
      end
      last = p0;
      lx = x0;
      ly = y0;
    end
  task automatic first_window();
    chk("first_oP_0", 32'(p0[0]), 32'h002);
    chk("first_oP_2", 32'(p0[2]), 32'h000);
    chk("first_oP_4", 32'(p0[4]), 32'h011);
    chk("first_oP_6", 32'(p0[6]), 32'h022);
    chk("first_oP_8", 32'(p0[8]), 32'h020);
    chk("first_oX_LSB", 32'(x0), 32'd1);
    chk("first_oY_LSB", 32'(y0), 32'd1);
    chk("first_oDVAL", 32'(v0), 32'd1);
    chk("first_phase_oX_LSB", 32'(x1), 32'd0);
    chk("first_phase_oY_LSB", 32'(y1), 32'd0);
    chk("first_phase_oP_4", 32'(p1[4]), 32'h011);
  endtask
  task automatic frame(bit gap, int n);
    int r, c;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      cycle(1'b0, 1'b1, pix(r, c));
      if (r == 2 && c == 2) first_window();
      if (gap) cycle(1'b0, 1'b0, 12'hABC);
    end
  endtask
  initial begin
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 12'h5A5);
    chk("reset_oP_4", 32'(p0[4]), 32'd0);
    chk("reset_oDVAL", 32'(v0), 32'd0);
    cycle(1'b0, 1'b0, 12'h123);
    cycle(1'b0, 1'b0, 12'h321);
    pulses = 0;
    frame(1'b0, W * H);
    frame(1'b0, W * H);
    cycle(1'b0, 1'b0, '0);
    chk("pulses_two_frames", 32'(pulses), 32'd48);
    pulses = 0;
    frame(1'b1, W * H);
    cycle(1'b0, 1'b0, '0);
    chk("pulses_gapped_frame", 32'(pulses), 32'd24);
    frame(1'b0, 3 * W + 4);
    cycle(1'b1, 1'b1, pix(3, 4));
    chk("midreset_oP_0", 32'(p0[0]), 32'd0);
    chk("midreset_oP_8", 32'(p0[8]), 32'd0);
    chk("midreset_oX_LSB", 32'(x0), 32'd0);
    chk("midreset_oY_LSB", 32'(y0), 32'd0);
    pulses = 0;
    frame(1'b0, W * H);
    cycle(1'b0, 1'b0, '0);
    chk("pulses_after_reset", 32'(pulses), 32'd24);
`ifdef RAW_WIN_FVAL_EN
    frame(1'b0, 3 * W + 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 12'hFFF, 1'b0);
    pulses = 0;
    frame(1'b0, W * H);
    cycle(1'b0, 1'b0, '0);
    chk("pulses_after_fval", 32'(pulses), 32'd24);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
